// File: rtl/fetch_unit_if.sv
// Instruction-bus read channels between the fetch stage (master) and the memory side (slave).
interface fetch_unit_if #(
  parameter int unsigned bus_width = 32
);
  logic                 i_raddr_valid;
  logic                 i_raddr_ready;
  logic [bus_width-1:0] i_raddr;
  logic                 i_rdata_valid;
  logic                 i_rdata_ready;
  logic [bus_width-1:0] i_rdata;

  modport master (
    output i_raddr_valid, i_raddr, i_rdata_ready,
    input  i_raddr_ready, i_rdata_valid, i_rdata
  );

  modport slave (
    input  i_raddr_valid, i_raddr, i_rdata_ready,
    output i_raddr_ready, i_rdata_valid, i_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: credit-limited instruction-bus reads, PC-tagged instruction FIFO to decode,
// redirect with flush and discard of in-flight responses.
module fetch_unit #(
  parameter int unsigned          bus_width  = 32,
  parameter int unsigned          pc_width   = 32,
  parameter logic [pc_width-1:0]  pc_init    = '0,
  parameter int unsigned          inst_width = 32,
  parameter int unsigned          fifo_depth = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_unit_if.master          ibus,
  input  logic                  jump_valid,
  input  logic [pc_width-1:0]   jump_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [inst_width-1:0] inst,
  output logic [pc_width-1:0]   inst_pc
);
  localparam int CW = $clog2(fifo_depth) + 1;
  localparam int AW = $clog2(fifo_depth);
  localparam logic [CW:0] DEPTH = (CW+1)'(fifo_depth);
  typedef logic [CW-1:0] cnt_t;

  logic [pc_width-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, hold_pc_q, hold_pc_d;
  cnt_t                out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic                held_q, held_d, stale_q, stale_d;
  logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [fifo_depth-1:0][inst_width-1:0] mem_inst_q;
  logic [fifo_depth-1:0][pc_width-1:0]   mem_pc_q;

  logic [CW:0]         used;
  logic                credit, req_valid, hs, rv, drop, push, pop;
  logic [pc_width-1:0] req_pc;

  assign used      = {1'b0, out_q} + {1'b0, cnt_q};
  assign credit    = used < DEPTH;
  assign req_valid = !rst && (credit || held_q);
  assign req_pc    = held_q ? hold_pc_q : fetch_pc_q;
  assign hs        = req_valid && ibus.i_raddr_ready;
  assign rv        = ibus.i_rdata_valid && !rst;
  assign drop      = rv && (disc_q != '0);
  assign push      = rv && !drop && !jump_valid;
  assign pop       = inst_valid && inst_ready && !jump_valid;

  assign ibus.i_raddr_valid = req_valid;
  assign ibus.i_raddr       = bus_width'(req_pc);
  assign ibus.i_rdata_ready = !rst;

  assign inst_valid = cnt_q != '0;
  assign inst       = mem_inst_q[rptr_q];
  assign inst_pc    = mem_pc_q[rptr_q];

  always_comb begin
    out_d      = out_q + cnt_t'(hs) - cnt_t'(rv);
    // A stale held address that finally gets accepted is owed a discard slot.
    disc_d     = disc_q - cnt_t'(drop) + cnt_t'(hs && stale_q);
    held_d     = req_valid && !ibus.i_raddr_ready;
    hold_pc_d  = req_pc;
    stale_d    = hs ? 1'b0 : stale_q;
    fetch_pc_d = (hs && !stale_q) ? fetch_pc_q + pc_width'(4) : fetch_pc_q;
    resp_pc_d  = push ? resp_pc_q + pc_width'(4) : resp_pc_q;
    cnt_d      = cnt_q + cnt_t'(push) - cnt_t'(pop);
    wptr_d     = wptr_q + AW'(push);
    rptr_d     = rptr_q + AW'(pop);
    if (jump_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      disc_d     = out_d;
      stale_d    = held_d;
      fetch_pc_d = jump_pc;
      resp_pc_d  = jump_pc;
      cnt_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= pc_init;
      resp_pc_q  <= pc_init;
      hold_pc_q  <= pc_init;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      held_q     <= 1'b0;
      stale_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int i = 0; i < int'(fifo_depth); i++) begin
        mem_inst_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      hold_pc_q  <= hold_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      stale_q    <= stale_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      if (push) begin
        mem_inst_q[wptr_q] <= ibus.i_rdata[inst_width-1:0];
        mem_pc_q[wptr_q]   <= resp_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap and async reset.
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b1, rst6 = 1'b1;
  int          cyc = 0, lat = 1, tests = 0, fails = 0;
  logic        ready_en = 1'b0, jump_valid = 1'b0, inst_ready = 1'b0, inv_bad = 1'b0;
  logic [31:0] jump_pc = '0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        jv6 = 1'b0, ir6 = 1'b1, iv6, prev_hs6 = 1'b0;
  logic [31:0] jpc6 = '0, in6, ipc6;
  logic [31:0] aq[$], iss[$], popc[$], popi[$], iss6[$];
  int          dq[$];

  fetch_unit_if bus();
  fetch_unit_if bus6();

  fetch_unit dut (
    .clk(clk), .rst(rst), .ibus(bus), .jump_valid(jump_valid), .jump_pc(jump_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  fetch_unit #(.pc_init(32'hFFFF_FFF8)) dut6 (
    .clk(clk), .rst(rst6), .ibus(bus6), .jump_valid(jv6), .jump_pc(jpc6),
    .inst_valid(iv6), .inst_ready(ir6), .inst(in6), .inst_pc(ipc6)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Bus models: main bus returns ~addr after 'lat' cycles; second bus returns one cycle later.
  always @(negedge clk) begin
    #1;
    bus.i_raddr_ready = ready_en;
    if (!rst && aq.size() > 0 && dq[0] <= cyc) begin
      bus.i_rdata_valid = 1'b1;
      bus.i_rdata = ~aq[0];
      void'(aq.pop_front());
      void'(dq.pop_front());
    end else begin
      bus.i_rdata_valid = 1'b0;
    end
    bus6.i_raddr_ready = 1'b1;
    bus6.i_rdata_valid = prev_hs6 && !rst6;
    bus6.i_rdata = 32'h13;
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus.i_raddr_valid && bus.i_raddr_ready) begin
        iss.push_back(bus.i_raddr);
        aq.push_back(bus.i_raddr);
        dq.push_back(cyc + lat);
      end
      if (inst_valid && inst_ready) begin
        popc.push_back(inst_pc);
        popi.push_back(inst);
      end
      if (dut.disc_q > dut.out_q || dut.out_q > 2) inv_bad = 1'b1;
    end
    prev_hs6 = !rst6 && bus6.i_raddr_valid && bus6.i_raddr_ready;
    if (prev_hs6) iss6.push_back(bus6.i_raddr);
  end

  task automatic do_reset(input int l, input logic rdy, input logic ir);
    @(negedge clk);
    rst = 1'b1; jump_valid = 1'b0; inst_ready = 1'b0; ready_en = 1'b0;
    aq.delete(); dq.delete(); iss.delete(); popc.delete(); popi.delete();
    repeat (2) @(negedge clk);
    lat = l; ready_en = rdy; inst_ready = ir; rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    bus.i_raddr_ready = 1'b0; bus.i_rdata_valid = 1'b0; bus.i_rdata = '0;
    repeat (2) @(negedge clk);
    tests++; if (bus.i_raddr_valid !== 1'b0) begin fails++; $display("FAIL rst_raddr_valid got %b exp 0", bus.i_raddr_valid); end
    tests++; if (bus.i_rdata_ready !== 1'b0) begin fails++; $display("FAIL rst_rdata_ready got %b exp 0", bus.i_rdata_ready); end
    tests++; if (bus.i_raddr !== 32'h0) begin fails++; $display("FAIL rst_raddr got %h exp 0", bus.i_raddr); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_inst_valid got %b exp 0", inst_valid); end
    tests++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin fails++; $display("FAIL rst_inst got %h/%h exp 0/0", inst, inst_pc); end
    rst = 1'b0;
    #1;
    tests++; if (bus.i_raddr_valid !== 1'b1) begin fails++; $display("FAIL first_req_valid got %b exp 1", bus.i_raddr_valid); end
    tests++; if (bus.i_rdata_ready !== 1'b1) begin fails++; $display("FAIL rdata_ready got %b exp 1", bus.i_rdata_ready); end
    got = bus.i_raddr;
    tests++; if (got !== 32'h0) begin fails++; $display("FAIL first_req_addr got %h exp 0", got); end
  endtask

  task automatic test_stream();
    logic prev_rv;
    logic [31:0] got;
    do_reset(1, 1'b1, 1'b1);
    #2 prev_rv = bus.i_rdata_valid;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      tests++; if (inst_valid !== prev_rv) begin fails++; $display("FAIL stream_latency c%0d got %b exp %b", k, inst_valid, prev_rv); end
      #2 prev_rv = bus.i_rdata_valid;
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < iss.size()) ? iss[i] : 32'hDEAD_BEEF;
      tests++; if (got !== 32'(4*i)) begin fails++; $display("FAIL stream_addr[%0d] got %h exp %h", i, got, 32'(4*i)); end
    end
    for (int i = 0; i < 5; i++) begin
      got = (i < popc.size()) ? popc[i] : 32'hDEAD_BEEF;
      tests++; if (got !== 32'(4*i)) begin fails++; $display("FAIL stream_pc[%0d] got %h exp %h", i, got, 32'(4*i)); end
      got = (i < popi.size()) ? popi[i] : 32'hDEAD_BEEF;
      tests++; if (got !== ~32'(4*i)) begin fails++; $display("FAIL stream_inst[%0d] got %h exp %h", i, got, ~32'(4*i)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] got;
    do_reset(1, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    tests++; if (iss.size() !== 2) begin fails++; $display("FAIL bp_req_count got %0d exp 2", iss.size()); end
    tests++; if (bus.i_raddr_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_drop got %b exp 0", bus.i_raddr_valid); end
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin fails++; $display("FAIL bp_full_head got %b/%h exp 1/0", inst_valid, inst_pc); end
    inst_ready = 1'b1;
    repeat (6) @(negedge clk);
    got = (iss.size() > 2) ? iss[2] : 32'hDEAD_BEEF;
    tests++; if (got !== 32'h8) begin fails++; $display("FAIL bp_resume_addr got %h exp 8", got); end
    for (int i = 0; i < 3; i++) begin
      got = (i < popc.size()) ? popc[i] : 32'hDEAD_BEEF;
      tests++; if (got !== exp_pc[i]) begin fails++; $display("FAIL bp_pc[%0d] got %h exp %h", i, got, exp_pc[i]); end
    end
  endtask

  task automatic test_jump_inflight();
    logic [31:0] exp_a [4] = '{32'h0, 32'h4, 32'h100, 32'h104};
    logic [31:0] got;
    do_reset(3, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (bus.i_raddr_valid !== 1'b0) begin fails++; $display("FAIL ji_no_credit got %b exp 0", bus.i_raddr_valid); end
    jump_valid = 1'b1; jump_pc = 32'h100;
    @(negedge clk);
    jump_valid = 1'b0;
    repeat (14) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      got = (i < iss.size()) ? iss[i] : 32'hDEAD_BEEF;
      tests++; if (got !== exp_a[i]) begin fails++; $display("FAIL ji_addr[%0d] got %h exp %h", i, got, exp_a[i]); end
    end
    got = (popc.size() > 0) ? popc[0] : 32'hDEAD_BEEF;
    tests++; if (got !== 32'h100) begin fails++; $display("FAIL ji_pc0 got %h exp 100", got); end
    got = (popi.size() > 0) ? popi[0] : 32'hDEAD_BEEF;
    tests++; if (got !== ~32'h100) begin fails++; $display("FAIL ji_inst0 got %h exp %h", got, ~32'h100); end
    got = (popc.size() > 1) ? popc[1] : 32'hDEAD_BEEF;
    tests++; if (got !== 32'h104) begin fails++; $display("FAIL ji_pc1 got %h exp 104", got); end
  endtask

  task automatic test_jump_held();
    logic [31:0] got;
    int n;
    do_reset(1, 1'b1, 1'b1);
    n = 0;
    while (iss.size() < 2 && n < 20) begin @(negedge clk); n++; end
    tests++; if (iss.size() < 2) begin fails++; $display("FAIL jh_wait got %0d exp 2", iss.size()); end
    ready_en = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.i_raddr_valid !== 1'b1 || bus.i_raddr !== 32'h8) begin fails++; $display("FAIL jh_pending got %b/%h exp 1/8", bus.i_raddr_valid, bus.i_raddr); end
    jump_valid = 1'b1; jump_pc = 32'h40;
    @(negedge clk);
    jump_valid = 1'b0;
    tests++; if (bus.i_raddr_valid !== 1'b1 || bus.i_raddr !== 32'h8) begin fails++; $display("FAIL jh_hold1 got %b/%h exp 1/8", bus.i_raddr_valid, bus.i_raddr); end
    @(negedge clk);
    tests++; if (bus.i_raddr_valid !== 1'b1 || bus.i_raddr !== 32'h8) begin fails++; $display("FAIL jh_hold2 got %b/%h exp 1/8", bus.i_raddr_valid, bus.i_raddr); end
    ready_en = 1'b1;
    repeat (12) @(negedge clk);
    got = (iss.size() > 2) ? iss[2] : 32'hDEAD_BEEF;
    tests++; if (got !== 32'h8) begin fails++; $display("FAIL jh_addr2 got %h exp 8", got); end
    got = (iss.size() > 3) ? iss[3] : 32'hDEAD_BEEF;
    tests++; if (got !== 32'h40) begin fails++; $display("FAIL jh_addr3 got %h exp 40", got); end
    got = (popc.size() > 2) ? popc[2] : 32'hDEAD_BEEF;
    tests++; if (got !== 32'h40) begin fails++; $display("FAIL jh_pc2 got %h exp 40", got); end
    got = (popi.size() > 2) ? popi[2] : 32'hDEAD_BEEF;
    tests++; if (got !== ~32'h40) begin fails++; $display("FAIL jh_inst2 got %h exp %h", got, ~32'h40); end
  endtask

  task automatic test_jump_pop_resp();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h200, 32'h204};
    logic [31:0] got;
    do_reset(1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    jump_valid = 1'b1; jump_pc = 32'h200;
    #2;
    tests++; if (inst_valid !== 1'b1 || bus.i_rdata_valid !== 1'b1) begin fails++; $display("FAIL jpr_setup got %b/%b exp 1/1", inst_valid, bus.i_rdata_valid); end
    @(negedge clk);
    jump_valid = 1'b0;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL jpr_flushed got %b exp 0", inst_valid); end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      got = (i < popc.size()) ? popc[i] : 32'hDEAD_BEEF;
      tests++; if (got !== exp_pc[i]) begin fails++; $display("FAIL jpr_pc[%0d] got %h exp %h", i, got, exp_pc[i]); end
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] exp_a [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    logic [31:0] got;
    int n;
    @(negedge clk);
    iss6.delete();
    rst6 = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      got = (i < iss6.size()) ? iss6[i] : 32'hDEAD_BEEF;
      tests++; if (got !== exp_a[i]) begin fails++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, got, exp_a[i]); end
    end
    n = 0;
    while (!bus6.i_raddr_valid && n < 10) begin @(negedge clk); n++; end
    tests++; if (bus6.i_raddr_valid !== 1'b1) begin fails++; $display("FAIL wrap_midburst got %b exp 1", bus6.i_raddr_valid); end
    rst6 = 1'b1;
    #1;
    tests++; if (bus6.i_raddr_valid !== 1'b0 || iv6 !== 1'b0) begin fails++; $display("FAIL async_rst got %b/%b exp 0/0", bus6.i_raddr_valid, iv6); end
    tests++; if (bus6.i_raddr !== 32'hFFFF_FFF8) begin fails++; $display("FAIL async_rst_addr got %h exp fffffff8", bus6.i_raddr); end
    @(negedge clk);
    iss6.delete();
    rst6 = 1'b0;
    repeat (2) @(negedge clk);
    got = (iss6.size() > 0) ? iss6[0] : 32'hDEAD_BEEF;
    tests++; if (got !== 32'hFFFF_FFF8) begin fails++; $display("FAIL restart_addr got %h exp fffffff8", got); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_inflight();
    test_jump_held();
    test_jump_pop_resp();
    test_wrap_reset();
    tests++; if (inv_bad !== 1'b0) begin fails++; $display("FAIL counter_invariant got %b exp 0", inv_bad); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
